fb_write_ctrl: RTL and testbench
================================

# fb_write_ctrl

Write-side controller for the 512x384 24-bit frame buffer. It takes the byte stream from the UART receiver (R, G, B order), assembles it into pixels and drives BRAM port A with address, data and a single-cycle write strobe. It tracks frame position and wraps at end of frame. It resynchronises pixel phase after idle gaps and on software clear, so a dropped byte cannot permanently skew colours.

## Interface
- IMG_W, 512, image width in pixels
- IMG_H, 384, image height in pixels
- TIMEOUT_CYC, 100000, idle clocks after which a partial pixel is discarded (1 ms at 100 MHz)
- clock  in  1  system clock (100 MHz domain, same as UART receiver and BRAM port A)
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- sync_clr  in  1  synchronous clear: phase and address to 0
- wr_addr  out  18  BRAM port A address
- wr_data  out  24  pixel {R,G,B}
- wr_en  out  1  BRAM port A write enable, one cycle per pixel
- frame_done  out  1  one-cycle pulse coincident with write of last pixel
- phase  out  2  current byte phase (0=R, 1=G, 2=B), for debug

## Operation
- FSM states: ST_R, ST_G, ST_B. ST_R→ST_G→ST_B→ST_R, one step per accepted byte. rx_valid is always accepted; there is no back-pressure.
- ST_R stores rx_data in r_q. ST_G stores it in g_q. ST_B captures {r_q, g_q, rx_data} into wr_data and asserts wr_en on the next cycle.
- wr_addr is the address of the pixel being written. It increments by 1 on the cycle after each write.
- FB_DEPTH = IMG_W*IMG_H (196608 by default).
  - The write at wr_addr = FB_DEPTH-1 raises frame_done with that wr_en.
  - The next address is 0. Plain +1 must never reach FB_DEPTH.
- sync_clr: next state ST_R, the partial pixel is discarded and wr_addr is 0. If a write is pending that cycle, it completes at its old address first.
- sync_clr together with rx_valid: the byte is taken as R of pixel 0.
- Gap timer (when enabled): counts clocks since the last rx_valid while phase≠ST_R. At TIMEOUT_CYC it forces ST_R without changing wr_addr.
- Timeout together with rx_valid: the byte is taken as R.
- Priority: reset > sync_clr > timeout > rx_valid.

## Timing
- Reset values: wr_addr=0, wr_data=0, wr_en=0, frame_done=0, phase=0, FSM=ST_R, gap counter=0.
- Latency: B byte on rx_valid at cycle N → wr_en=1 at N+1, with wr_addr and wr_data stable during N+1. wr_addr advances at N+2.
- Back-to-back rx_valid at every clock is supported: one pixel per 3 clocks, no loss.
- Reset asserted mid-pixel or mid-frame returns everything to reset values immediately. Any pending write is dropped.
- Arithmetic: 18-bit unsigned address. Compare wr_addr against FB_DEPTH-1 before incrementing. The gap counter is sized $clog2(TIMEOUT_CYC+1) and saturates.

## Configuration
- FB_GAP_RESYNC_EN
  - Defined: the gap timer is present and timeout resync operates as above.
  - Undefined: no timer logic is built, phase resyncs only on sync_clr or reset, and TIMEOUT_CYC is ignored.

## Structure
- Package fb_pkg holds:
  - the state enum (ST_R, ST_G, ST_B)
  - FB_ADDR_W = 18
  - FB_PIX_W = 24
  - default IMG_W/IMG_H
  - the FB_DEPTH function
- One sub-module, fb_gap_timer: clear on rx_valid, run enable when phase≠ST_R, one-cycle expire output. It is instantiated only under FB_GAP_RESYNC_EN.

## Test plan
- Bytes 0x12, 0x34, 0x56 after reset → wr_en one cycle after 0x56, wr_addr=0, wr_data=0x123456. Next pixel writes at wr_addr=1.
- IMG_W=4, IMG_H=2, 8 pixels back-to-back → frame_done only with the write at wr_addr=7. The 9th pixel writes at wr_addr=0.
- Macro defined, TIMEOUT_CYC=50:
  - Send 0xAA, 0xBB, wait 60 clocks, send 0x01, 0x02, 0x03 → exactly one write, wr_data=0x010203, wr_addr=0.
  - Same stimulus without the macro → the write is 0xAABB01.
- sync_clr after 5 pixels plus 1 byte, coincident with rx_valid=0x11, followed by 0x22, 0x33 → write at wr_addr=0 with 0x112233.
- reset asserted the cycle after the third byte → no wr_en, all outputs 0. Next 3 bytes write at wr_addr=0.
- rx_valid every clock for 30 bytes → 10 writes at addresses 0..9, each wr_en a single cycle, data matching the stream.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and sizing for the frame-buffer write path.
// Holds the byte-phase enum, bus widths and frame depth helper.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_R = 2'd0,
    ST_G = 2'd1,
    ST_B = 2'd2
  } fb_state_e;

  localparam int unsigned FB_ADDR_W = 18;
  localparam int unsigned FB_PIX_W  = 24;
  localparam int unsigned FB_IMG_W  = 512;
  localparam int unsigned FB_IMG_H  = 384;

  function automatic int unsigned FB_DEPTH(
    input int unsigned w,
    input int unsigned h
  );
    return w * h;
  endfunction

endpackage

// File: rtl/fb_gap_timer.sv
// Idle-gap timer: saturating clock count since the last byte,
// one-cycle expire while the pixel phase is mid-pixel.
module fb_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Phase leaves mid-pixel on expiry, so this stays a single pulse.
  assign expire_o = run_i & (cnt_q == LIM);

endmodule

// File: rtl/fb_write_ctrl.sv
// Byte-to-pixel assembler driving BRAM port A of the frame buffer.
// Define FB_GAP_RESYNC_EN to build the idle-gap phase resync timer.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned IMG_W       = FB_IMG_W,
  parameter int unsigned IMG_H       = FB_IMG_H,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 sync_clr_i,
  output logic [FB_ADDR_W-1:0] wr_addr_o,
  output logic [FB_PIX_W-1:0]  wr_data_o,
  output logic                 wr_en_o,
  output logic                 frame_done_o,
  output logic [1:0]           phase_o
);

  localparam int unsigned DEPTH = FB_DEPTH(IMG_W, IMG_H);
  localparam logic [FB_ADDR_W-1:0] LAST = FB_ADDR_W'(DEPTH - 1);

  fb_state_e             state_q, state_d;
  logic [7:0]            r_q, r_d;
  logic [7:0]            g_q, g_d;
  logic [FB_PIX_W-1:0]   wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic [FB_ADDR_W-1:0]  addr_q, addr_d;
  logic [FB_ADDR_W-1:0]  addr_nxt;
  logic                  at_last;
  logic                  gap_expire;

`ifdef FB_GAP_RESYNC_EN
  fb_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .clr_i    (rx_valid_i),
    .run_i    (state_q != ST_R),
    .expire_o (gap_expire)
  );
`else
  // TIMEOUT_CYC has no effect in this build.
  assign gap_expire = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  assign at_last  = (addr_q == LAST);
  assign addr_nxt = at_last ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    addr_d  = wen_q ? addr_nxt : addr_q;
    if (sync_clr_i) begin
      // A pending write keeps its old address this cycle.
      addr_d  = '0;
      state_d = ST_R;
      if (rx_valid_i) begin
        r_d     = rx_data_i;
        state_d = ST_G;
      end
    end else if (gap_expire) begin
      state_d = ST_R;
      if (rx_valid_i) begin
        r_d     = rx_data_i;
        state_d = ST_G;
      end
    end else if (rx_valid_i) begin
      unique case (state_q)
        ST_R: begin
          r_d     = rx_data_i;
          state_d = ST_G;
        end
        ST_G: begin
          g_d     = rx_data_i;
          state_d = ST_B;
        end
        ST_B: begin
          wdata_d = {r_q, g_q, rx_data_i};
          wen_d   = 1'b1;
          state_d = ST_R;
        end
        default: state_d = ST_R;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_R;
      r_q     <= '0;
      g_q     <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
    end
  end

  assign wr_addr_o    = addr_q;
  assign wr_data_o    = wdata_q;
  assign wr_en_o      = wen_q;
  assign frame_done_o = wen_q & at_last;
  assign phase_o      = state_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Scoreboard bench for fb_write_ctrl on a 4x2 frame,
// timeout 50 clocks; gap expectations follow FB_GAP_RESYNC_EN.
module tb_fb_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        sync_clr = 1'b0;
  logic [17:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;
  logic        frame_done;
  logic [1:0]  phase;

  always #5 clk = ~clk;

  fb_write_ctrl #(
    .IMG_W       (4),
    .IMG_H       (2),
    .TIMEOUT_CYC (50)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .sync_clr_i   (sync_clr),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .wr_en_o      (wr_en),
    .frame_done_o (frame_done),
    .phase_o      (phase)
  );

  typedef struct packed {
    logic [17:0] a;
    logic [23:0] d;
    logic        fd;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_en = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_px(input logic [17:0] a,
                           input logic [23:0] d,
                           input logic fd);
    exp_t e;
    e.a  = a;
    e.d  = d;
    e.fd = fd;
    q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic clr);
    rx_data  = b;
    rx_valid = 1'b1;
    sync_clr = clr;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic pixel(input logic [23:0] p);
    send(p[23:16], 1'b0);
    send(p[15:8], 1'b0);
    send(p[7:0], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_only();
    sync_clr = 1'b1;
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
  endtask

  function automatic logic [7:0] sb(input int j);
    return 8'(j * 7 + 1);
  endfunction

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (wr_en) begin
        check("wr_en_single", 32'(prev_en), 32'd0);
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h",
                   wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.a));
          check("wr_data", 32'(wr_data), 32'(e.d));
          check("frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else begin
        check("frame_done_idle", 32'(frame_done), 32'd0);
      end
      prev_en = wr_en;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First pixel and latency.
    expect_px(18'd0, 24'h123456, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    check("latency_wr_en", 32'(wr_en), 32'd1);
    expect_px(18'd1, 24'hABCDEF, 1'b0);
    pixel(24'hABCDEF);
    idle(3);

    // Frame wrap on a 4x2 frame.
    clr_only();
    for (int i = 0; i < 9; i++) begin
      expect_px(18'(i % 8), {8'(i), 8'(i + 16), 8'(i + 32)},
                (i == 7));
      pixel({8'(i), 8'(i + 16), 8'(i + 32)});
    end
    idle(3);
    check("wrap_phase", 32'(phase), 32'd0);

    // Idle gap after two bytes.
    clr_only();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    idle(60);
`ifdef FB_GAP_RESYNC_EN
    expect_px(18'd0, 24'h010203, 1'b0);
`else
    expect_px(18'd0, 24'hAABB01, 1'b0);
`endif
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    idle(3);
`ifdef FB_GAP_RESYNC_EN
    check("gap_phase", 32'(phase), 32'd0);
`else
    check("gap_phase", 32'(phase), 32'd2);
`endif

    // sync_clr with a coincident byte after 5 pixels + 1 byte.
    clr_only();
    for (int i = 0; i < 5; i++) begin
      expect_px(18'(i), {8'hC0, 8'(i), 8'h5A}, 1'b0);
      pixel({8'hC0, 8'(i), 8'h5A});
    end
    send(8'h99, 1'b0);
    expect_px(18'd0, 24'h112233, 1'b0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    idle(3);

    // Reset right after the third byte drops the write.
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_phase", 32'(phase), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_px(18'd0, 24'h778899, 1'b0);
    pixel(24'h778899);
    idle(3);

    // 30 bytes back to back.
    clr_only();
    for (int k = 0; k < 10; k++) begin
      expect_px(18'(k % 8),
                {sb(3 * k), sb(3 * k + 1), sb(3 * k + 2)},
                (k % 8 == 7));
    end
    for (int j = 0; j < 30; j++) begin
      send(sb(j), 1'b0);
    end
    idle(5);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
